// File: rtl/riscv_pipe_ctrl_if.sv
// riscv_pipe_ctrl_if: hazard/sequencing bus between the pipeline datapath and riscv_pipe_ctrl
//   decode/execute status in : rs1addr_d, rs2addr_d, rdaddr_e, resultsrc_e, pcsrc_e, mstart_e, dstart_e
//   register controls out     : stall_f, stall_d, stall_e, flush_d, flush_e, flush_m
//   mul/div status out        : mdvalid, busy
//   performance out           : stallcnt
//   master = datapath side, slave = controller side
interface riscv_pipe_ctrl_if;
    logic [4:0]  rs1addr_d;
    logic [4:0]  rs2addr_d;
    logic [4:0]  rdaddr_e;
    logic [1:0]  resultsrc_e;
    logic        pcsrc_e;
    logic        mstart_e;
    logic        dstart_e;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        flush_d;
    logic        flush_e;
    logic        flush_m;
    logic        mdvalid;
    logic        busy;
    logic [31:0] stallcnt;

    modport master (
        output rs1addr_d, rs2addr_d, rdaddr_e, resultsrc_e, pcsrc_e, mstart_e, dstart_e,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdvalid, busy, stallcnt
    );

    modport slave (
        input  rs1addr_d, rs2addr_d, rdaddr_e, resultsrc_e, pcsrc_e, mstart_e, dstart_e,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdvalid, busy, stallcnt
    );
endinterface

// File: rtl/riscv_pipe_ctrl.sv
// riscv_pipe_ctrl: stall/flush controller for the FD/DE/EM pipeline registers
//   i_riscv_pctrl_clk : clock, rising edge
//   i_riscv_pctrl_rst : asynchronous reset, active-high
//   bus (slave)       : decode/execute hazard inputs, stall/flush/mdvalid/busy/stallcnt outputs
//   Handles load-use bubbles, branch redirects and multi-cycle MUL/DIV holds in execute.
//   Optional stall-cycle counter enabled by defining RISCV_PCTRL_PERF_EN.
module riscv_pipe_ctrl #(
    parameter int         MUL_LATENCY = 4,
    parameter int         DIV_LATENCY = 34,
    parameter logic [1:0] LOAD_SRC    = 2'b01
) (
    input logic               i_riscv_pctrl_clk,
    input logic               i_riscv_pctrl_rst,
    riscv_pipe_ctrl_if.slave  bus
);
    localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rst, start, seq, load_use, stall_f;

    assign rst = i_riscv_pctrl_rst;

    // A start is only recognised in IDLE; the same op stays in E through BUSY/DONE.
    assign start    = state == IDLE && (bus.mstart_e || bus.dstart_e);
    assign seq      = start || state == BUSY;
    // Load-use is not evaluated while a sequence is holding the front end.
    assign load_use = state != BUSY && bus.resultsrc_e == LOAD_SRC && bus.rdaddr_e != 5'd0 &&
                      (bus.rdaddr_e == bus.rs1addr_d || bus.rdaddr_e == bus.rs2addr_d);

    // Outputs gated by rst so the reset values hold even while inputs are active.
    assign stall_f     = !rst && (seq || (!bus.pcsrc_e && load_use));
    assign bus.stall_f = stall_f;
    assign bus.stall_d = stall_f;
    assign bus.stall_e = !rst && seq;
    assign bus.flush_d = rst || (!seq && bus.pcsrc_e);
    assign bus.flush_e = rst || (!seq && (bus.pcsrc_e || load_use));
    assign bus.flush_m = rst || seq;
    assign bus.mdvalid = !rst && state == DONE;
    assign bus.busy    = !rst && seq;

    always_comb begin
        state_n = state == BUSY ? (cnt <= CW'(1) ? DONE : BUSY) : (start ? BUSY : IDLE);
        cnt_n   = start ? (bus.dstart_e ? CW'(DIV_LATENCY - 1) : CW'(MUL_LATENCY - 1)) :
                  (state == BUSY && cnt > CW'(1)) ? cnt - CW'(1) : cnt;
    end

    always_ff @(posedge i_riscv_pctrl_clk or posedge i_riscv_pctrl_rst) begin
        if (i_riscv_pctrl_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef RISCV_PCTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge i_riscv_pctrl_clk or posedge i_riscv_pctrl_rst) begin
        if (i_riscv_pctrl_rst)
            perf_q <= '0;
        else if (stall_f && perf_q != '1)
            perf_q <= perf_q + 32'd1;
    end

    assign bus.stallcnt = perf_q;
`else
    assign bus.stallcnt = 32'd0;
`endif
endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb_riscv_pipe_ctrl: directed scoreboard bench for riscv_pipe_ctrl
module tb_riscv_pipe_ctrl;
    // Expected control vector order: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdvalid, busy}
    localparam logic [7:0] V_NONE = 8'b000_000_00;
    localparam logic [7:0] V_LU   = 8'b110_010_00;
    localparam logic [7:0] V_BR   = 8'b000_110_00;
    localparam logic [7:0] V_SEQ  = 8'b111_001_01;
    localparam logic [7:0] V_DONE = 8'b000_000_10;
    localparam logic [7:0] V_DLU  = 8'b110_010_10;
    localparam logic [7:0] V_RST  = 8'b000_111_00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   ncmp = 0;
    int   nfail = 0;
    logic [31:0] exp_cnt = 0;
    logic [7:0]  sb[$];

    riscv_pipe_ctrl_if bus();

    riscv_pipe_ctrl dut (
        .i_riscv_pctrl_clk (clk),
        .i_riscv_pctrl_rst (rst),
        .bus               (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e,
                bus.flush_m, bus.mdvalid, bus.busy};
    endfunction

    function automatic logic [31:0] exp_stallcnt(input logic [31:0] c);
`ifdef RISCV_PCTRL_PERF_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    task automatic check(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        if (sb.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        o = obs_vec();
        ncmp++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, o, e);
        end
        ncmp++;
        assert (bus.stallcnt === exp_stallcnt(exp_cnt)) else begin
            nfail++;
            $error("FAIL %s stallcnt: observed %0d expected %0d", tag, bus.stallcnt, exp_stallcnt(exp_cnt));
        end
        if (e[7] && !rst) exp_cnt++;
    endtask

    task automatic drive(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] rsrc, input logic pc,
                         input logic ms, input logic ds, input logic [7:0] e);
        bus.rs1addr_d   = rs1;
        bus.rs2addr_d   = rs2;
        bus.rdaddr_e    = rd;
        bus.resultsrc_e = rsrc;
        bus.pcsrc_e     = pc;
        bus.mstart_e    = ms;
        bus.dstart_e    = ds;
        sb.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        exp_cnt = 0;
        sb.push_back(V_RST);
        #1;
        check(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.rs1addr_d = 0; bus.rs2addr_d = 0; bus.rdaddr_e = 0; bus.resultsrc_e = 0;
        bus.pcsrc_e = 0; bus.mstart_e = 0; bus.dstart_e = 0;
        do_reset("reset");
        drive("idle", 5'd1, 5'd2, 5'd3, 2'b00, 0, 0, 0, V_NONE);
        // MUL: four stall cycles, result at T+4 with mstart still high, no restart
        for (int i = 0; i < 4; i++) drive("mul_hold", 0, 0, 0, 2'b00, 0, 1, 0, V_SEQ);
        drive("mul_done", 0, 0, 0, 2'b00, 0, 1, 0, V_DONE);
        drive("mul_after", 0, 0, 0, 2'b00, 0, 0, 0, V_NONE);
        // Load-use bubble
        drive("lu_rs1", 5'd5, 5'd0, 5'd5, 2'b01, 0, 0, 0, V_LU);
        drive("lu_rd0", 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, V_NONE);
        ncmp++;
        assert (bus.stallcnt === exp_stallcnt(32'd5)) else begin
            nfail++;
            $error("FAIL perf_5: observed %0d expected %0d", bus.stallcnt, exp_stallcnt(32'd5));
        end
        drive("lu_rs2", 5'd1, 5'd9, 5'd9, 2'b01, 0, 0, 0, V_LU);
        drive("lu_notload", 5'd9, 5'd9, 5'd9, 2'b10, 0, 0, 0, V_NONE);
        drive("lu_nomatch", 5'd1, 5'd2, 5'd9, 2'b01, 0, 0, 0, V_NONE);
        // Branch
        drive("br_lu", 5'd5, 5'd0, 5'd5, 2'b01, 1, 0, 0, V_BR);
        drive("br_only", 5'd1, 5'd2, 5'd3, 2'b00, 1, 0, 0, V_BR);
        // Start with a branch: sequence wins; load-use ignored while busy
        drive("br_start", 5'd5, 0, 5'd5, 2'b01, 1, 1, 0, V_SEQ);
        for (int i = 0; i < 3; i++) drive("mul_lu", 5'd5, 0, 5'd5, 2'b01, 0, 1, 0, V_SEQ);
        drive("done_lu", 5'd5, 0, 5'd5, 2'b01, 0, 1, 0, V_DLU);
        drive("post", 0, 0, 0, 2'b00, 0, 0, 0, V_NONE);
        // MUL+DIV together: DIV latency wins
        for (int i = 0; i < 34; i++) drive("div_hold", 0, 0, 0, 2'b00, 0, 1, 1, V_SEQ);
        drive("div_done", 0, 0, 0, 2'b00, 0, 1, 1, V_DONE);
        drive("div_after", 0, 0, 0, 2'b00, 0, 0, 0, V_NONE);
        // Reset at DIV cycle 10 aborts the sequence
        for (int i = 0; i < 10; i++) drive("div_pre", 0, 0, 0, 2'b00, 0, 0, 1, V_SEQ);
        do_reset("reset_mid");
        bus.dstart_e = 0;
        for (int i = 0; i < 4; i++) drive("mul2_hold", 0, 0, 0, 2'b00, 0, 1, 0, V_SEQ);
        drive("mul2_done", 0, 0, 0, 2'b00, 0, 1, 0, V_DONE);
        drive("mul2_after", 0, 0, 0, 2'b00, 0, 0, 0, V_NONE);
        ncmp++;
        assert (sb.size() == 0) else begin
            nfail++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
